// File: rtl/div_pkg.sv
// Shared constants and helpers for the multi-cycle integer divider.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    function automatic logic [RegBus-1:0] neg32(input logic [RegBus-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div.sv
// Restoring 32/32 divider (signed/unsigned) producing {remainder, quotient}.
// Latency: result valid after edge 34 from start (edge 2 for a zero divisor).
// Backpressure: start_i held high keeps the result; dropping it or annul_i frees the unit.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_t              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [64:0]             dividend_q, dividend_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic                    sgn_q, sgn_d;
    logic                    neg1_q, neg1_d;
    logic                    neg2_q, neg2_d;
    logic [DoubleRegBus-1:0] result_d;
    logic                    ready_d;

    // dividend_q layout: [64:33] partial remainder, [32:1] unconsumed dividend
    // bits shifting up, quotient bits entering at [0]. The 33-bit trial uses
    // [64:32], so a remainder with bit 31 set is never truncated.
    logic [32:0]       trial;
    logic [RegBus-1:0] op1_mag, op2_mag, quot_fix, rem_fix;

    assign trial    = dividend_q[64:32] - {1'b0, divisor_q};
    assign op1_mag  = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
    assign op2_mag  = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
    assign quot_fix = (sgn_q && (neg1_q ^ neg2_q)) ? neg32(dividend_q[31:0]) : dividend_q[31:0];
    assign rem_fix  = (sgn_q && neg1_q) ? neg32(dividend_q[64:33]) : dividend_q[64:33];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sgn_d      = sgn_q;
        neg1_d     = neg1_q;
        neg2_d     = neg2_q;
        result_d   = result_o;
        ready_d    = ready_o;
        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    sgn_d      = signed_div_i;
                    neg1_d     = opdata1_i[31];
                    neg2_d     = opdata2_i[31];
                    divisor_d  = op2_mag;
                    dividend_d = {32'd0, op1_mag, 1'b0};
                    cnt_d      = 6'd0;
                    state_d    = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                dividend_d = '0;
                state_d    = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    cnt_d   = 6'd0;
                    state_d = DivFree;
                end else if (cnt_q != 6'd32) begin
                    if (trial[32])
                        dividend_d = {dividend_q[63:0], 1'b0};
                    else
                        dividend_d = {trial[31:0], dividend_q[31:0], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    dividend_d = {rem_fix, 1'b0, quot_fix};
                    cnt_d      = 6'd0;
                    state_d    = DivEnd;
                end
            end
            DivEnd: begin
                result_d = {dividend_q[64:33], dividend_q[31:0]};
                ready_d  = DivResultReady;
                if (start_i == DivStop || annul_i) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end
            end
            default: begin
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= 6'd0;
            dividend_q <= '0;
            divisor_q  <= '0;
            sgn_q      <= 1'b0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            result_o   <= '0;
            ready_o    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sgn_q      <= sgn_d;
            neg1_q     <= neg1_d;
            neg2_q     <= neg2_d;
            result_o   <= result_d;
            ready_o    <= ready_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: hand-computed quotient/remainder vectors,
// exact latency, hold/release, annul, divide-by-zero and asynchronous reset.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request and advances 'edges' clock edges (edge 0 latches).
    // early = ready seen before the last edge; rdy/res = outputs after the last.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int edges, output logic early, output logic rdy,
                          output logic [63:0] res);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        early        = 1'b0;
        for (int e = 0; e < edges; e++) begin
            @(posedge clk);
            #1;
            if (e < edges - 1 && ready_o) early = 1'b1;
        end
        rdy = ready_o;
        res = result_o;
    endtask

    task automatic release_start();
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 0", ready_o);
        end
        n_cmp++;
        if (result_o !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 0", result_o);
        end
    endtask

    task automatic test_unsigned_basic();
        logic early, rdy;
        logic [63:0] res;
        run_op(1'b0, 32'd100, 32'd7, 35, early, rdy, res);
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL u100_7_early: ready before edge 34 got %b want 0", early);
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL u100_7_ready: got %b want 1", rdy);
        end
        n_cmp++;
        if (res !== 64'h00000002_0000000E) begin
            n_bad++;
            $display("FAIL u100_7_result: got %h want 000000020000000e", res);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
            n_bad++;
            $display("FAIL u100_7_hold: got rdy=%b res=%h want rdy=1 res=000000020000000e",
                     ready_o, result_o);
        end
        release_start();
        n_cmp++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_bad++;
            $display("FAIL u100_7_release: got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        logic early, rdy;
        logic [63:0] res;
        run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 35, early, rdy, res);
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_bad++;
            $display("FAIL s_m7_2: got rdy=%b res=%h want rdy=1 res=fffffffffffffffd", rdy, res);
        end
        release_start();
        run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 35, early, rdy, res);
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'h00000001_FFFFFFFD) begin
            n_bad++;
            $display("FAIL s_7_m2: got rdy=%b res=%h want rdy=1 res=00000001fffffffd", rdy, res);
        end
        release_start();
        run_op(1'b0, 32'hFFFFFFF9, 32'h00000002, 35, early, rdy, res);
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'h00000001_7FFFFFFC) begin
            n_bad++;
            $display("FAIL u_fff9_2: got rdy=%b res=%h want rdy=1 res=000000017ffffffc", rdy, res);
        end
        release_start();
    endtask

    task automatic test_div_by_zero();
        logic early, rdy;
        logic [63:0] res;
        run_op(1'b0, 32'd5, 32'd0, 3, early, rdy, res);
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL dbz_early: ready before edge 2 got %b want 0", early);
        end
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'h0) begin
            n_bad++;
            $display("FAIL dbz_result: got rdy=%b res=%h want rdy=1 res=0", rdy, res);
        end
        release_start();
        n_cmp++;
        if (ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL dbz_release: got rdy=%b want 0", ready_o);
        end
    endtask

    task automatic test_annul();
        logic early, rdy, rose;
        logic [63:0] res;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        rose         = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) rose = 1'b1;
        end
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        if (ready_o) rose = 1'b1;
        annul_i = 1'b0;
        n_cmp++;
        if (rose !== 1'b0 || result_o !== 64'h0) begin
            n_bad++;
            $display("FAIL annul_quiet: got rose=%b res=%h want 0/0", rose, result_o);
        end
        run_op(1'b0, 32'd9, 32'd3, 35, early, rdy, res);
        n_cmp++;
        if (early !== 1'b0 || rdy !== 1'b1 || res !== 64'h00000000_00000003) begin
            n_bad++;
            $display("FAIL annul_restart: got early=%b rdy=%b res=%h want 0/1/0000000000000003",
                     early, rdy, res);
        end
        release_start();
    endtask

    task automatic test_boundaries();
        logic early, rdy;
        logic [63:0] res;
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 35, early, rdy, res);
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'h00000000_80000000) begin
            n_bad++;
            $display("FAIL s_minint_m1: got rdy=%b res=%h want rdy=1 res=0000000080000000", rdy, res);
        end
        release_start();
        run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 35, early, rdy, res);
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'h00000000_FFFFFFFF) begin
            n_bad++;
            $display("FAIL u_max_1: got rdy=%b res=%h want rdy=1 res=00000000ffffffff", rdy, res);
        end
        release_start();
        run_op(1'b0, 32'hFFFFFFFF, 32'h80000001, 35, early, rdy, res);
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'h7FFFFFFE_00000001) begin
            n_bad++;
            $display("FAIL u_max_big: got rdy=%b res=%h want rdy=1 res=7ffffffe00000001", rdy, res);
        end
        release_start();
    endtask

    task automatic test_operand_change();
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd10;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFFF9;
        opdata2_i    = 32'd3;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000000_00000064) begin
            n_bad++;
            $display("FAIL opchange: got rdy=%b res=%h want rdy=1 res=0000000000000064",
                     ready_o, result_o);
        end
        release_start();
    endtask

    task automatic test_back_to_back();
        logic early, rdy;
        logic [63:0] res;
        run_op(1'b0, 32'd50, 32'd8, 35, early, rdy, res);
        n_cmp++;
        if (rdy !== 1'b1 || res !== 64'h00000002_00000006) begin
            n_bad++;
            $display("FAIL b2b_first: got rdy=%b res=%h want rdy=1 res=0000000200000006", rdy, res);
        end
        release_start();
        run_op(1'b1, 32'hFFFFFF9C, 32'h00000007, 35, early, rdy, res);
        n_cmp++;
        if (early !== 1'b0 || rdy !== 1'b1 || res !== 64'hFFFFFFFE_FFFFFFF2) begin
            n_bad++;
            $display("FAIL b2b_second: got early=%b rdy=%b res=%h want 0/1/fffffffefffffff2",
                     early, rdy, res);
        end
        release_start();
    endtask

    task automatic test_reset_mid_op();
        logic early, rdy;
        logic [63:0] res;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_mid_on: got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        #1;
        rst = 1'b0;
        run_op(1'b0, 32'd9, 32'd3, 35, early, rdy, res);
        n_cmp++;
        if (early !== 1'b0 || rdy !== 1'b1 || res !== 64'h00000000_00000003) begin
            n_bad++;
            $display("FAIL rst_restart: got early=%b rdy=%b res=%h want 0/1/0000000000000003",
                     early, rdy, res);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_in_end: got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        #2;
        test_reset();
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_unsigned_basic();
        test_signed();
        test_div_by_zero();
        test_annul();
        test_boundaries();
        test_operand_change();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
